// File: rtl/display_pkg.sv
// Shared types and constants for the multiplexed 7-segment scan controller.
package display_pkg;

  typedef logic [1:0] scan_state_t;

  localparam scan_state_t OFF   = 2'd0;
  localparam scan_state_t BLANK = 2'd1;
  localparam scan_state_t SHOW  = 2'd2;

  typedef struct packed {
    logic       ext;
    logic [3:0] special;
    logic [3:0] d;
  } digit_cfg_t;

  localparam logic [3:0] SPECIAL_BLANK = 4'b1111;

  // A suppressed leading zero is sent to the decoder as its blank code.
  function automatic digit_cfg_t apply_blank(input digit_cfg_t cfg, input logic blank);
    digit_cfg_t result;
    result = cfg;
    if (blank) begin
      result.ext     = 1'b0;
      result.special = SPECIAL_BLANK;
      result.d       = 4'd0;
    end
    return result;
  endfunction

endpackage

// File: rtl/peripheral_scan_timer.sv
// Slot counter for the display scan: runs 0..SLOT_CYC-1 across one digit slot.
module peripheral_scan_timer #(
  parameter int SLOT_CYC  = 50000,
  parameter int BLANK_CYC = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic blank_done,
  output logic slot_done
);

  localparam int CNT_W = $clog2(SLOT_CYC);

  logic [CNT_W-1:0] count_reg;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_reg + 1'b1;
    end
  end

  assign blank_done = (count_reg == CNT_W'(BLANK_CYC - 1));
  assign slot_done  = (count_reg == CNT_W'(SLOT_CYC - 1));

endmodule

// File: rtl/peripheral_display_scan.sv
// Scan controller: double-buffered digit codes, blank/show slot FSM,
// leading-zero suppression and active-low anode drive for one shared decoder.
module peripheral_display_scan
  import display_pkg::*;
#(
  parameter int N_DIGITS  = 4,
  parameter int SLOT_CYC  = 50000,
  parameter int BLANK_CYC = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic                lz_en,
  input  logic                wr_en,
  input  logic [2:0]          wr_addr,
  input  logic [8:0]          wr_data,
  output logic                wr_ack,
  output logic [3:0]          dec_d,
  output logic [3:0]          dec_special,
  output logic                dec_ext,
  output logic [31:0]         dec_deco,
  output logic [N_DIGITS-1:0] an_n,
  output logic                frame_start
);

  localparam int IDX_W = $clog2(N_DIGITS);

  scan_state_t state_reg, state_next;
  logic [IDX_W-1:0] idx_reg, idx_next;
  logic commit, step;
  logic blank_done, slot_done, timer_clear;
  logic wr_hit;

  digit_cfg_t shadow_reg [N_DIGITS];
  digit_cfg_t active_reg [N_DIGITS];
  digit_cfg_t dec_reg;
  logic [N_DIGITS-1:0] blank_mask_reg;
  logic [N_DIGITS-1:0] shadow_zero, shadow_blank;
  logic frame_start_reg, wr_ack_reg;

  assign wr_hit = wr_en && (int'(wr_addr) < N_DIGITS);

  // The mask is taken from shadow because it becomes the active set at commit.
  for (genvar gi = 0; gi < N_DIGITS; gi++) begin : g_lz
    assign shadow_zero[gi] = (shadow_reg[gi] == '0);
    if (gi == 0) begin : g_first
      assign shadow_blank[gi] = 1'b0;
    end else begin : g_upper
      assign shadow_blank[gi] = lz_en && (&shadow_zero[N_DIGITS-1:gi]);
    end
  end

  peripheral_scan_timer #(
    .SLOT_CYC (SLOT_CYC),
    .BLANK_CYC(BLANK_CYC)
  ) u_timer (
    .clk       (clk),
    .reset     (reset),
    .clear     (timer_clear),
    .blank_done(blank_done),
    .slot_done (slot_done)
  );

  assign timer_clear = (state_reg == OFF) || !enable || (state_reg == SHOW && slot_done);

  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    commit     = 1'b0;
    step       = 1'b0;
    case (state_reg)
      OFF: begin
        if (enable) begin
          state_next = BLANK;
          idx_next   = '0;
          commit     = 1'b1;
          step       = 1'b1;
        end
      end
      BLANK: begin
        if (!enable) begin
          state_next = OFF;
          idx_next   = '0;
        end else if (blank_done) begin
          state_next = SHOW;
        end
      end
      SHOW: begin
        if (!enable) begin
          state_next = OFF;
          idx_next   = '0;
        end else if (slot_done) begin
          state_next = BLANK;
          step       = 1'b1;
          if (idx_reg == IDX_W'(N_DIGITS - 1)) begin
            idx_next = '0;
            commit   = 1'b1;
          end else begin
            idx_next = idx_reg + 1'b1;
          end
        end
      end
      default: begin
        state_next = OFF;
        idx_next   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg       <= OFF;
      idx_reg         <= '0;
      dec_reg         <= '0;
      blank_mask_reg  <= '0;
      frame_start_reg <= 1'b0;
      wr_ack_reg      <= 1'b0;
      for (int i = 0; i < N_DIGITS; i++) begin
        shadow_reg[i] <= '0;
        active_reg[i] <= '0;
      end
    end else begin
      state_reg       <= state_next;
      idx_reg         <= idx_next;
      frame_start_reg <= commit;
      wr_ack_reg      <= wr_hit;
      if (wr_hit) begin
        shadow_reg[wr_addr[IDX_W-1:0]] <= digit_cfg_t'(wr_data);
      end
      // Commit reads the pre-write shadow, so a same-cycle write waits a frame.
      if (commit) begin
        for (int i = 0; i < N_DIGITS; i++) begin
          active_reg[i] <= shadow_reg[i];
        end
        blank_mask_reg <= shadow_blank;
        dec_reg        <= apply_blank(shadow_reg[0], shadow_blank[0]);
      end else if (step) begin
        dec_reg <= apply_blank(active_reg[idx_next], blank_mask_reg[idx_next]);
      end
    end
  end

  always_comb begin
    an_n = '1;
    if (state_reg == SHOW) begin
      an_n[idx_reg] = 1'b0;
    end
  end

  assign dec_d       = dec_reg.d;
  assign dec_special = dec_reg.special;
  assign dec_ext     = dec_reg.ext;
  assign dec_deco    = {{(32 - IDX_W){1'b0}}, idx_reg};
  assign frame_start = frame_start_reg;
  assign wr_ack      = wr_ack_reg;

endmodule

// File: tb/tb_peripheral_display_scan.sv
// Directed bench for peripheral_display_scan with N_DIGITS=4, SLOT_CYC=20, BLANK_CYC=4.
module tb_peripheral_display_scan;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic        lz_en = 1'b0;
  logic        wr_en = 1'b0;
  logic [2:0]  wr_addr = 3'd0;
  logic [8:0]  wr_data = 9'd0;
  logic        wr_ack;
  logic [3:0]  dec_d;
  logic [3:0]  dec_special;
  logic        dec_ext;
  logic [31:0] dec_deco;
  logic [3:0]  an_n;
  logic        frame_start;

  int n_total = 0;
  int n_bad   = 0;

  peripheral_display_scan #(
    .N_DIGITS (4),
    .SLOT_CYC (20),
    .BLANK_CYC(4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .lz_en      (lz_en),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .wr_ack     (wr_ack),
    .dec_d      (dec_d),
    .dec_special(dec_special),
    .dec_ext    (dec_ext),
    .dec_deco   (dec_deco),
    .an_n       (an_n),
    .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [35:0] got, input logic [35:0] want);
    n_total++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s at %0t: got=%h want=%h", tag, $time, got, want);
    end
  endtask

  // One host write; ack_exp says whether the address is in range.
  task automatic wr(input logic [2:0] addr, input logic [8:0] data, input logic ack_exp);
    @(posedge clk);
    #1;
    wr_en   = 1'b1;
    wr_addr = addr;
    wr_data = data;
    @(posedge clk);
    #1;
    wr_en = 1'b0;
    @(negedge clk);
    chk("wr_ack_pulse", 36'(wr_ack), 36'(ack_exp));
    $display("write addr=%0d data=%h ack=%0b", addr, data, wr_ack);
    @(negedge clk);
    chk("wr_ack_drop", 36'(wr_ack), 36'd0);
  endtask

  // Entered at the negedge of a frame's first cycle; returns at the next frame's first cycle.
  // exp_all holds the expected {ext,special,d} for slot i at bits [i*9 +: 9].
  task automatic run_frame(input logic [35:0] exp_all);
    int slot;
    int pos;
    logic [3:0] an_exp;
    for (int k = 0; k < 80; k++) begin
      slot   = k / 20;
      pos    = k % 20;
      an_exp = (pos < 4) ? 4'hF : ~(4'b0001 << slot);
      chk("an_n", 36'(an_n), 36'(an_exp));
      chk("frame_start", 36'(frame_start), 36'(k == 0));
      if (pos == 0 || pos == 19) begin
        chk("dec_codes", 36'({dec_ext, dec_special, dec_d}), 36'(exp_all[slot*9 +: 9]));
        chk("dec_deco", 36'(dec_deco), 36'(slot));
      end
      @(negedge clk);
    end
    $display("frame done exp=%h", exp_all);
  endtask

  task automatic start_enable();
    @(posedge clk);
    #1;
    enable = 1'b1;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk("rst_an_n", 36'(an_n), 36'hF);
    chk("rst_dec", 36'({dec_ext, dec_special, dec_d}), 36'd0);
    chk("rst_deco", 36'(dec_deco), 36'd0);
    chk("rst_frame_start", 36'(frame_start), 36'd0);
    chk("rst_wr_ack", 36'(wr_ack), 36'd0);
    $display("reset checked");

    // Frame 1 shows zeros while digits 3..0 are written mid-frame
    start_enable();
    fork
      run_frame(36'h0);
      begin
        repeat (25) @(negedge clk);
        wr(3'd3, 9'h004, 1'b1);
        wr(3'd2, 9'h003, 1'b1);
        wr(3'd1, 9'h002, 1'b1);
        wr(3'd0, 9'h001, 1'b1);
      end
    join

    // Frame 2 shows 1..4; load {0,0,5,0} with leading-zero suppression on
    fork
      run_frame({9'h004, 9'h003, 9'h002, 9'h001});
      begin
        repeat (10) @(negedge clk);
        lz_en = 1'b1;
        wr(3'd3, 9'h000, 1'b1);
        wr(3'd2, 9'h000, 1'b1);
        wr(3'd1, 9'h005, 1'b1);
        wr(3'd0, 9'h000, 1'b1);
      end
    join

    // Frame 3: digits 3 and 2 blanked; out-of-range write must be ignored
    fork
      run_frame({9'h0F0, 9'h0F0, 9'h005, 9'h000});
      begin
        repeat (30) @(negedge clk);
        wr(3'd2, 9'h1AA, 1'b1);
        wr(3'd5, 9'h0FF, 1'b0);
      end
    join

    // Frame 4: digit 2 now non-zero, only digit 3 blanked
    run_frame({9'h0F0, 9'h1AA, 9'h005, 9'h000});

    // Drop enable in SHOW of digit 2
    repeat (50) @(negedge clk);
    chk("show2_an_n", 36'(an_n), 36'hB);
    @(posedge clk);
    #1;
    enable = 1'b0;
    @(negedge clk);
    chk("dis_same_cycle_an_n", 36'(an_n), 36'hB);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("off_an_n", 36'(an_n), 36'hF);
      chk("off_frame_start", 36'(frame_start), 36'd0);
      chk("off_deco", 36'(dec_deco), 36'd0);
    end
    $display("disable checked");
    start_enable();
    run_frame({9'h0F0, 9'h1AA, 9'h005, 9'h000});

    // Reset during BLANK of digit 3
    repeat (61) @(negedge clk);
    chk("blank3_an_n", 36'(an_n), 36'hF);
    chk("blank3_deco", 36'(dec_deco), 36'd3);
    @(posedge clk);
    #1;
    reset  = 1'b1;
    enable = 1'b0;
    lz_en  = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk("midrst_an_n", 36'(an_n), 36'hF);
    chk("midrst_dec", 36'({dec_ext, dec_special, dec_d}), 36'd0);
    chk("midrst_deco", 36'(dec_deco), 36'd0);
    chk("midrst_frame_start", 36'(frame_start), 36'd0);
    $display("mid-run reset checked");
    start_enable();
    run_frame(36'h0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
